// File: rtl/button_stepper_pkg.sv
// Shared types and constants for the button stepper: FSM states, direction
// indices and the arbitration order used by the stepper and its consumers.
package button_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        REPEAT
    } state_e;

    localparam int unsigned NUM_BTN = 4;

    localparam logic [1:0] DIR_UP    = 2'd3;
    localparam logic [1:0] DIR_DOWN  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd0;

    // Arbitration order matches the downstream counters: up > down > right > left.
    function automatic logic [1:0] pick_dir(input logic [NUM_BTN-1:0] levels);
        if (levels[DIR_UP])
            return DIR_UP;
        else if (levels[DIR_DOWN])
            return DIR_DOWN;
        else if (levels[DIR_RIGHT])
            return DIR_RIGHT;
        else
            return DIR_LEFT;
    endfunction

    function automatic logic [NUM_BTN-1:0] dir_onehot(input logic [1:0] dir);
        logic [NUM_BTN-1:0] vec;
        vec      = '0;
        vec[dir] = 1'b1;
        return vec;
    endfunction

endpackage

// File: rtl/button_stepper_debounce.sv
// Two-flop synchroniser followed by a stability counter; a level change is
// accepted only after DEBOUNCE_CYCLES consecutive cycles of disagreement.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned CNT_W           = 26
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic stable
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             meta_q;
    logic             sync_q;
    logic             stable_q;
    logic             stable_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Any cycle of agreement restarts the count, so short glitches never land.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync_q != stable_q) begin
            if (cnt_q == CNT_LAST)
                stable_d = ~stable_q;
            else
                cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q   <= 1'b0;
            sync_q   <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            meta_q   <= btn_raw;
            sync_q   <= meta_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable = stable_q;

endmodule

// File: rtl/button_stepper.sv
// Debounces four direction buttons, arbitrates them to one direction and
// emits single-cycle step strobes with typematic auto-repeat.
module button_stepper
    import button_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned REPEAT_DELAY    = 50_000_000,
    parameter int unsigned REPEAT_PERIOD   = 10_000_000,
    parameter int unsigned CNT_W           = 26
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         btn_up_raw,
    input  logic         btn_down_raw,
    input  logic         btn_left_raw,
    input  logic         btn_right_raw,
    output logic         up,
    output logic         down,
    output logic         left,
    output logic         right,
    output logic [3:0]   pressed
);

    localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

    logic [NUM_BTN-1:0] raw_vec;
    logic [NUM_BTN-1:0] stable_vec;
    logic [NUM_BTN-1:0] pressed_q;
    logic [NUM_BTN-1:0] strobe_q;
    state_e             state_q;
    logic [1:0]         dir_q;
    logic [CNT_W-1:0]   timer_q;

    assign raw_vec[DIR_UP]    = btn_up_raw;
    assign raw_vec[DIR_DOWN]  = btn_down_raw;
    assign raw_vec[DIR_RIGHT] = btn_right_raw;
    assign raw_vec[DIR_LEFT]  = btn_left_raw;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_deb
        btn_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_deb (
            .clk     (clk),
            .rst_n   (rst_n),
            .btn_raw (raw_vec[i]),
            .stable  (stable_vec[i])
        );
    end

    // Registering the debounced levels keeps every output off any input path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pressed_q <= '0;
        else
            pressed_q <= stable_vec;
    end

    // Release of the latched direction wins over timer expiry in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            dir_q    <= DIR_UP;
            timer_q  <= '0;
            strobe_q <= '0;
        end else begin
            strobe_q <= '0;
            unique case (state_q)
                IDLE: begin
                    if (|pressed_q) begin
                        dir_q    <= pick_dir(pressed_q);
                        strobe_q <= dir_onehot(pick_dir(pressed_q));
                        timer_q  <= '0;
                        state_q  <= DELAY;
                    end
                end
                DELAY: begin
                    if (!pressed_q[dir_q]) begin
                        state_q <= IDLE;
                    end else if (timer_q == DELAY_LAST) begin
                        strobe_q <= dir_onehot(dir_q);
                        timer_q  <= '0;
                        state_q  <= REPEAT;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                REPEAT: begin
                    if (!pressed_q[dir_q]) begin
                        state_q <= IDLE;
                    end else if (timer_q == PERIOD_LAST) begin
                        strobe_q <= dir_onehot(dir_q);
                        timer_q  <= '0;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign up      = strobe_q[DIR_UP];
    assign down    = strobe_q[DIR_DOWN];
    assign right   = strobe_q[DIR_RIGHT];
    assign left    = strobe_q[DIR_LEFT];
    assign pressed = pressed_q;

endmodule
